alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Instruction-issue controller that drives the team's 16-bit combinational ALU.
- It accepts 16-bit instruction words over a valid/ready handshake and decodes them into ALU op codes.
- It reads operands from an internal 8-entry register file, drives the ALU, captures the ALU result and writes it back.
- It is the initiator for the ALU's op/operand/result interface: it generates op codes the ALU consumes rather than consuming them.

Parameters:
DATA_WIDTH, 16, width of registers, ALU operands and result.
REG_AW, 3, register address width; register file depth is 2**REG_AW.

Ports:
clock  input  1  single system clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
instr_valid  input  1  instr_data is valid this cycle.
instr_ready  output  1  controller can accept an instruction; high only in IDLE.
instr_data  input  16  instruction: [15:12] opcode, [11:9] rd, [8:6] rs, [5:3] rt, [2:0] reserved (ignored).
alu_a  output  DATA_WIDTH  ALU operand A (registered).
alu_b  output  DATA_WIDTH  ALU operand B (registered).
alu_op  output  4  ALU op code (registered): 0 add, 1 sub, 2 and, 3 or; bits [3:2] always 0.
alu_result  input  DATA_WIDTH  combinational ALU output.
wb_valid  output  1  one-cycle pulse when a register write commits.
wb_addr  output  REG_AW  destination register of the write.
wb_data  output  DATA_WIDTH  value written.
illegal_op  output  1  one-cycle pulse on an undefined opcode.
dbg_addr  input  REG_AW  debug read address.
dbg_data  output  DATA_WIDTH  combinational read of register dbg_addr.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE; all registers = 0.
  - alu_a = alu_b = 0, alu_op = 0.
  - wb_valid = 0, wb_addr = 0, wb_data = 0, illegal_op = 0.
  - instr_ready = 1 (decoded from IDLE).
  - Reset asserted mid-instruction aborts it: no writeback, no pulse.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR: rd <= rs op rt.
  - 4 LI: rd <= zero-extend(instr[8:0]); the ALU is not used.
  - 5..15: illegal.
- FSM states: IDLE, DECODE, EXECUTE, WRITEBACK.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready: latch instr_data and go to DECODE.
  - Otherwise stay in IDLE.
- DECODE:
  - ALU opcode: register alu_a <= reg[rs], alu_b <= reg[rt], alu_op <= opcode[1:0] zero-extended; go to EXECUTE.
  - LI: load the result register with the immediate; go to WRITEBACK.
  - Illegal: assert illegal_op for this cycle only; return to IDLE; alu_* outputs unchanged; no writeback.
- EXECUTE: capture alu_result into the result register; go to WRITEBACK.
- WRITEBACK:
  - reg[rd] <= result; wb_valid = 1 with wb_addr = rd, wb_data = result for this cycle only.
  - Go to IDLE.
- wb_addr and wb_data hold their last values when wb_valid = 0.
- Latency, counted from the acceptance edge:
  - ALU op: wb_valid high 3 cycles later; instr_ready high again 4 cycles after acceptance.
  - LI: wb_valid high 2 cycles later.
  - Illegal: illegal_op high 1 cycle later.
- Throughput: at most one instruction in flight; instr_ready = 0 in every non-IDLE state. instr_valid and instr_data are ignored outside IDLE.
- Arithmetic is modulo 2**DATA_WIDTH, performed in the ALU. The controller does no arithmetic.
- Hazards: the writeback commits before the next DECODE, so back-to-back dependent instructions always see the updated value. rd may equal rs or rt.
- dbg_data is a combinational read. Reading the register being written in WRITEBACK returns the old value that cycle and the new value from the next cycle.
- All registers are writable; there is no hardwired zero register.

Test Plan:
- Reset, then LI r1,0x1FF -> wb_valid 2 cycles after accept; wb_addr=1, wb_data=0x01FF; dbg_addr=1 reads 0x01FF afterward.
- LI r1,5; LI r2,3; ADD r3,r1,r2 -> in EXECUTE alu_a=5, alu_b=3, alu_op=0; wb_data=8 at wb_addr 3, 3 cycles after accept.
- SUB r4,r2,r1 (3-5) -> alu_op=1, wb_data=0xFFFE (wrap-around).
- With r1=0x00F0, r2=0x0F0F: AND r5,r1,r2 -> 0x0000; OR r6,r1,r2 -> 0x0FFF.
- instr_data with opcode 0x9 -> illegal_op pulses one cycle, no wb_valid, all registers unchanged, instr_ready back at 1 on the next cycle.
- Hold instr_valid high continuously with 3 queued instructions -> exactly 3 accepts, each 4 cycles apart.
- Assert reset_n low during EXECUTE of ADD -> outputs clear immediately, no wb_valid, registers read 0, instr_ready = 1.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_issue_ctrl: decodes instruction words, drives the external ALU from an
// 8-entry register file and writes results back, one instruction at a time.
// Revision: 1.0
// ----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_AW     = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [15:0]           instr_data,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  wb_valid,
  output logic [REG_AW-1:0]     wb_addr,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  illegal_op,
  input  logic [REG_AW-1:0]     dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int c_DEPTH = 1 << REG_AW;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DECODE    = 2'd1,
    S_EXECUTE   = 2'd2,
    S_WRITEBACK = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [15:0]           r_instr;
  logic [DATA_WIDTH-1:0] r_regs [c_DEPTH];
  logic [DATA_WIDTH-1:0] r_result;
  logic [REG_AW-1:0]     r_wb_addr;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [1:0]            r_alu_op;

  logic [3:0]            w_opcode;
  logic [REG_AW-1:0]     w_rd;
  logic [REG_AW-1:0]     w_rs;
  logic [REG_AW-1:0]     w_rt;
  logic [DATA_WIDTH-1:0] w_imm;
  logic                  w_accept;
  logic                  w_load_alu;
  logic                  w_load_li;
  logic                  w_capture;
  logic                  w_commit;

  assign w_opcode = r_instr[15:12];
  assign w_rd     = REG_AW'(r_instr[11:9]);
  assign w_rs     = REG_AW'(r_instr[8:6]);
  assign w_rt     = REG_AW'(r_instr[5:3]);
  assign w_imm    = DATA_WIDTH'(r_instr[8:0]);
  assign w_accept = instr_valid & instr_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    instr_ready  = 1'b0;
    wb_valid     = 1'b0;
    illegal_op   = 1'b0;
    w_load_alu   = 1'b0;
    w_load_li    = 1'b0;
    w_capture    = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          w_next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_opcode < 4'd4) begin
          w_load_alu   = 1'b1;
          w_next_state = S_EXECUTE;
        end else if (w_opcode == 4'd4) begin
          w_load_li    = 1'b1;
          w_next_state = S_WRITEBACK;
        end else begin
          illegal_op   = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_EXECUTE: begin
        w_capture    = 1'b1;
        w_next_state = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        wb_valid     = 1'b1;
        w_commit     = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // r_result doubles as the held wb_data; it only changes when a new result is produced
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_instr   <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_result  <= '0;
      r_wb_addr <= '0;
    end else begin
      if (w_accept) begin
        r_instr <= instr_data;
      end
      if (w_load_alu) begin
        r_alu_a  <= r_regs[w_rs];
        r_alu_b  <= r_regs[w_rt];
        r_alu_op <= w_opcode[1:0];
      end
      if (w_load_li) begin
        r_result  <= w_imm;
        r_wb_addr <= w_rd;
      end
      if (w_capture) begin
        r_result  <= alu_result;
        r_wb_addr <= w_rd;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[r_wb_addr] <= r_result;
    end
  end

  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_op   = {2'b00, r_alu_op};
  assign wb_addr  = r_wb_addr;
  assign wb_data  = r_result;
  assign dbg_data = r_regs[dbg_addr];

endmodule
`default_nettype wire
